sd_sector_writer: RTL and testbench

SD_SECTOR_WRITER -- requirements
Module: sd_sector_writer

---
 rtl/sd_sector_writer.sv | 164 ++++++++++++++++
 tb/tb_sd_sector_writer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/sd_sector_writer.sv
// sd_sector_writer: sends one 512-byte sector on SD DAT0 and collects the card's CRC status and busy.
//   clk, rstn            system clock, asynchronous active-low reset
//   sdclk                SD clock from the command controller, edge-detected in the clk domain
//   wstart/wbusy/wdone   transfer start, in-progress flag, 1-clk completion pulse
//   wstatus              0 ok, 1 crc error, 2 write error, 3 timeout; held until the next wstart
//   inreq/inaddr/inbyte  byte fetch strobe, byte address, byte returned on the clk after inreq
//   sddat0_o/_oe/_i      DAT0 drive value, drive enable, pad input
module sd_sector_writer #(
  parameter int STAT_TIMEOUT = 64,
  parameter int BUSY_TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sdclk,
  input  logic       wstart,
  output logic       wbusy,
  output logic       wdone,
  output logic [1:0] wstatus,
  output logic       inreq,
  output logic [8:0] inaddr,
  input  logic [7:0] inbyte,
  output logic       sddat0_o,
  output logic       sddat0_oe,
  input  logic       sddat0_i
);
  localparam int TW = $clog2((BUSY_TIMEOUT > STAT_TIMEOUT ? BUSY_TIMEOUT : STAT_TIMEOUT) + 1) + 1;
  typedef enum logic [3:0] {IDLE, PRE, START, DATA, CRC, ENDB, REL, SWAIT, SBITS, BWAIT, FIN} state_t;
  state_t        state_q;
  logic          sdclkl_q, pend_q, wbusy_q, wdone_q, inreq_q, dat_q, oe_q;
  logic [1:0]    wstatus_q;
  logic [8:0]    inaddr_q;
  logic [11:0]   cnt_q;
  logic [15:0]   crc_q;
  logic [7:0]    sh_q, buf_q;
  logic [2:0]    tok_q;
  logic [TW-1:0] tmo_q;
  logic          rise, fall, first, dbit;
  assign rise  = ~sdclkl_q & sdclk;
  assign fall  = sdclkl_q & ~sdclk;
  // the first bit of every byte comes straight from the prefetch buffer
  assign first = cnt_q[2:0] == 3'd0;
  assign dbit  = first ? buf_q[7] : sh_q[7];
  assign wbusy     = wbusy_q;
  assign wdone     = wdone_q;
  assign wstatus   = wstatus_q;
  assign inreq     = inreq_q;
  assign inaddr    = inaddr_q;
  assign sddat0_o  = dat_q;
  assign sddat0_oe = oe_q;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      sdclkl_q  <= 1'b0;
      pend_q    <= 1'b0;
      wbusy_q   <= 1'b0;
      wdone_q   <= 1'b0;
      wstatus_q <= 2'd0;
      inreq_q   <= 1'b0;
      inaddr_q  <= 9'd0;
      dat_q     <= 1'b1;
      oe_q      <= 1'b0;
      cnt_q     <= 12'd0;
      crc_q     <= 16'd0;
      sh_q      <= 8'd0;
      buf_q     <= 8'd0;
      tok_q     <= 3'd0;
      tmo_q     <= '0;
    end else begin
      sdclkl_q <= sdclk;
      pend_q   <= inreq_q;
      if (pend_q) buf_q <= inbyte;
      inreq_q <= 1'b0;
      wdone_q <= 1'b0;
      case (state_q)
        IDLE: if (wstart) begin
          state_q   <= PRE;
          wbusy_q   <= 1'b1;
          inreq_q   <= 1'b1;
          inaddr_q  <= 9'd0;
          cnt_q     <= 12'd0;
          wstatus_q <= 2'd0;
        end
        PRE: if (fall) begin
          dat_q <= 1'b1;
          oe_q  <= 1'b1;
          cnt_q <= cnt_q == 12'd7 ? 12'd0 : cnt_q + 12'd1;
          if (cnt_q == 12'd7) state_q <= START;
        end
        START: if (fall) begin
          dat_q   <= 1'b0;
          crc_q   <= 16'd0;
          cnt_q   <= 12'd0;
          state_q <= DATA;
        end
        DATA: if (fall) begin
          dat_q <= dbit;
          crc_q <= {crc_q[14:0], 1'b0} ^ ({16{crc_q[15] ^ dbit}} & 16'h1021);
          sh_q  <= first ? {buf_q[6:0], 1'b0} : {sh_q[6:0], 1'b0};
          // prefetch the next byte while the current one shifts out
          if (first && inaddr_q != 9'd511) begin
            inreq_q  <= 1'b1;
            inaddr_q <= inaddr_q + 9'd1;
          end
          cnt_q <= cnt_q + 12'd1;
          if (cnt_q == 12'd4095) state_q <= CRC;
        end
        CRC: if (fall) begin
          dat_q <= crc_q[15];
          crc_q <= {crc_q[14:0], 1'b0};
          cnt_q <= cnt_q == 12'd15 ? 12'd0 : cnt_q + 12'd1;
          if (cnt_q == 12'd15) state_q <= ENDB;
        end
        ENDB: if (fall) begin
          dat_q   <= 1'b1;
          state_q <= REL;
        end
        REL: if (fall) begin
          oe_q    <= 1'b0;
          tmo_q   <= '0;
          state_q <= SWAIT;
        end
        SWAIT: if (rise) begin
          if (!sddat0_i) begin
            cnt_q   <= 12'd0;
            state_q <= SBITS;
          end else if (tmo_q == TW'(STAT_TIMEOUT - 1)) begin
            wstatus_q <= 2'd3;
            state_q   <= FIN;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        SBITS: if (rise) begin
          if (cnt_q < 12'd3) begin
            tok_q <= {tok_q[1:0], sddat0_i};
            cnt_q <= cnt_q + 12'd1;
          end else begin
            // this rise is the status end bit; the token is complete
            wstatus_q <= tok_q == 3'b010 ? 2'd0 : tok_q == 3'b101 ? 2'd1 : 2'd2;
            cnt_q     <= 12'd0;
            tmo_q     <= '0;
            state_q   <= BWAIT;
          end
        end
        BWAIT: if (rise) begin
          if (sddat0_i) begin
            state_q <= FIN;
          end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
            wstatus_q <= 2'd3;
            state_q   <= FIN;
          end else begin
            tmo_q <= tmo_q + TW'(1);
          end
        end
        FIN: begin
          wdone_q <= 1'b1;
          wbusy_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_sector_writer.sv
// tb_sd_sector_writer: randomized sector writes checked against a bit-level reference of the DAT0 protocol.
module tb_sd_sector_writer;
  localparam int BT = 120;
  logic       clk = 1'b0;
  logic       rstn, sdclk, wstart, wbusy, wdone, inreq, sddat0_o, sddat0_oe, sddat0_i;
  logic [1:0] wstatus;
  logic [8:0] inaddr;
  logic [7:0] inbyte;
  logic [7:0] mem [512];
  bit         cap[$], expq[$], card_q[$];
  int         n_chk = 0, n_pass = 0;
  int         done_cnt = 0, done_st = 0, done_rise = 0, rises = 0;
  int         req_cnt = 0, exp_addr = 0, addr_err = 0;
  bit         armed = 1'b0, tick = 1'b0;
  sd_sector_writer #(.STAT_TIMEOUT(64), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rstn(rstn), .sdclk(sdclk), .wstart(wstart), .wbusy(wbusy), .wdone(wdone),
    .wstatus(wstatus), .inreq(inreq), .inaddr(inaddr), .inbyte(inbyte),
    .sddat0_o(sddat0_o), .sddat0_oe(sddat0_oe), .sddat0_i(sddat0_i)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask
  function automatic logic [15:0] crc_of();
    logic [15:0] c;
    c = 16'd0;
    for (int i = 0; i < 512; i++)
      for (int b = 7; b >= 0; b--)
        c = {c[14:0], 1'b0} ^ ((c[15] ^ mem[i][b]) ? 16'h1021 : 16'h0000);
    return c;
  endfunction
  // sdclk generator (period 4 clk), memory responder, card responder and observers, all away from posedge
  always @(negedge clk) begin
    if (wdone) begin
      done_cnt++;
      done_st   = int'(wstatus);
      done_rise = rises;
    end
    if (inreq) begin
      req_cnt++;
      if (int'(inaddr) != exp_addr) addr_err++;
      exp_addr++;
      inbyte = mem[inaddr];
    end
    if (sddat0_oe) begin
      armed = 1'b1;
      rises = 0;
    end
    tick = !tick;
    if (tick) begin
      if (sdclk) begin
        if (sddat0_oe) cap.push_back(sddat0_o);
        if (armed && !sddat0_oe) begin
          if (card_q.size() > 0) sddat0_i = card_q.pop_front();
          else sddat0_i = 1'b1;
        end
        sdclk = 1'b0;
      end else begin
        sdclk = 1'b1;
        if (!sddat0_oe) rises++;
      end
    end
  end
  task automatic pulse_start();
    @(negedge clk) wstart = 1'b1;
    @(negedge clk) wstart = 1'b0;
  endtask
  task automatic run(input int mode, input bit stat, input logic [2:0] tok, input int d, input int busy,
                     input int exp_st, input int exp_rise, input bit reass);
    int d0, t, mis;
    logic [15:0] c, got;
    for (int i = 0; i < 512; i++) mem[i] = mode == 0 ? 8'hFF : mode == 1 ? 8'(i) : 8'($urandom);
    c = crc_of();
    expq.delete();
    repeat (8) expq.push_back(1'b1);
    expq.push_back(1'b0);
    for (int i = 0; i < 512; i++)
      for (int b = 7; b >= 0; b--) expq.push_back(mem[i][b]);
    for (int b = 15; b >= 0; b--) expq.push_back(c[b]);
    expq.push_back(1'b1);
    cap.delete();
    card_q.delete();
    req_cnt = 0; exp_addr = 0; addr_err = 0; armed = 1'b0; sddat0_i = 1'b1;
    if (stat) begin
      repeat (d) card_q.push_back(1'b1);
      card_q.push_back(1'b0);
      for (int b = 2; b >= 0; b--) card_q.push_back(tok[b]);
      card_q.push_back(1'b1);
      repeat (busy) card_q.push_back(1'b0);
    end
    d0 = done_cnt;
    pulse_start();
    if (reass) begin
      t = 0;
      while (req_cnt < 100 && t < 20000) begin @(posedge clk); t++; end
      pulse_start();
    end
    t = 0;
    while (done_cnt == d0 && t < 25000) begin @(posedge clk); t++; end
    chk("done_seen", int'(done_cnt != d0), 1);
    repeat (60) @(posedge clk);
    chk("done_once", done_cnt - d0, 1);
    chk("status", done_st, exp_st);
    chk("status_held", int'(wstatus), exp_st);
    chk("done_rise", done_rise, exp_rise);
    chk("bit_count", cap.size(), 4122);
    mis = 0;
    for (int i = 0; i < cap.size() && i < expq.size(); i++) mis += int'(cap[i] != expq[i]);
    chk("stream_mis", mis, 0);
    got = 16'd0;
    if (cap.size() >= 4121)
      for (int k = 0; k < 16; k++) got = {got[14:0], cap[4105 + k]};
    chk("crc_field", int'(got), int'(c));
    if (mode == 0) chk("crc_ff", int'(got), 32'h7FA1);
    chk("inreq_cnt", req_cnt, 512);
    chk("inaddr_order", addr_err, 0);
    chk("busy_clear", int'(wbusy), 0);
  endtask
  initial begin
    int d0, t, d, b;
    rstn = 1'b0; wstart = 1'b0; sdclk = 1'b0; sddat0_i = 1'b1; inbyte = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst_wbusy", int'(wbusy), 0);
    chk("rst_wdone", int'(wdone), 0);
    chk("rst_wstatus", int'(wstatus), 0);
    chk("rst_inreq", int'(inreq), 0);
    chk("rst_inaddr", int'(inaddr), 0);
    chk("rst_dat", int'(sddat0_o), 1);
    chk("rst_oe", int'(sddat0_oe), 0);
    @(negedge clk) rstn = 1'b1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    req_cnt = 0; exp_addr = 0; addr_err = 0; armed = 1'b0;
    d0 = done_cnt;
    pulse_start();
    t = 0;
    while (req_cnt < 202 && t < 20000) begin @(posedge clk); t++; end
    chk("abort_reach", int'(req_cnt >= 202), 1);
    chk("abort_oe_before", int'(sddat0_oe), 1);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    chk("abort_oe", int'(sddat0_oe), 0);
    chk("abort_wbusy", int'(wbusy), 0);
    chk("abort_dat", int'(sddat0_o), 1);
    repeat (4) @(negedge clk);
    rstn = 1'b1;
    repeat (300) @(posedge clk);
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle_oe", int'(sddat0_oe), 0);
    run(0, 1'b1, 3'b010, 2, 100, 0, 2 + 7 + 100, 1'b0);
    d = $urandom_range(0, 4); b = $urandom_range(0, 20);
    run(1, 1'b1, 3'b101, d, b, 1, d + 7 + b, 1'b1);
    d = $urandom_range(0, 4); b = $urandom_range(0, 20);
    run(2, 1'b1, 3'b110, d, b, 2, d + 7 + b, 1'b0);
    run(2, 1'b0, 3'b000, 0, 0, 3, 64, 1'b0);
    d = $urandom_range(0, 4);
    run(2, 1'b1, 3'b010, d, 300, 3, d + 6 + BT, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
